uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receive path, the counterpart of the UART Tx chain. Oversamples the serial line
//  RX_IN at PRESCALE clocks per bit and deframes start/data/parity/stop, LSB first.
//  Emits the parallel byte with a one-cycle DATA_VALID pulse, or an error pulse.
//  Sits between the pad-side RX synchroniser and the RX data-sync/register-file logic.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame
//  PRESCALE_W   6   width of PRESCALE input and of the internal edge counter
// PORTS
//  CLK         in   1           system clock, all logic on rising edge
//  RST         in   1           asynchronous, active-low reset
//  RX_IN       in   1           serial line, idle high, already synchronised to CLK
//  PRESCALE    in   PRESCALE_W  clocks per bit; legal 8..32, even
//  PAR_EN      in   1           1 = parity bit present after data
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  P_DATA      out  DATA_WIDTH  last good received word, registered
//  DATA_VALID  out  1           1-cycle pulse, P_DATA updated same cycle
//  PAR_ERR     out  1           1-cycle pulse, parity mismatch in frame
//  STP_ERR     out  1           1-cycle pulse, stop bit sampled 0
//  RX_BUSY     out  1           high whenever FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE, counters 0; P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, RX_BUSY=0.
//    Reset mid-frame aborts it; no pulse is emitted for the partial frame.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: the cycle RX_IN==0 is seen is edge 0 of the start bit; PRESCALE, PAR_EN,
//    PAR_TYP are latched then. Changes to them mid-frame are ignored.
//  - edge_cnt runs 0..PRESCALE-1 per bit; bit decision is taken at edge_cnt==PRESCALE-1.
//    Sample point S = PRESCALE/2.
//  - START: sampled bit 1 -> false start, back to IDLE, no outputs. Sampled bit 0 -> DATA.
//  - DATA: shift sampled bits in LSB first. After DATA_WIDTH bits go to PARITY if PAR_EN,
//    else go to STOP.
//  - PARITY: expected bit = ^data XOR PAR_TYP. The mismatch is held in a flag until STOP.
//  - STOP, at edge_cnt==PRESCALE-1, outputs registered on the next clock edge:
//      * stop==1 and no parity flag: P_DATA<=word, DATA_VALID=1.
//      * parity flag set: PAR_ERR=1.
//      * stop==0: STP_ERR=1. PAR_ERR and STP_ERR may pulse together.
//      * On any error DATA_VALID stays 0 and P_DATA holds its old value.
//    Next state is IDLE.
//  - Latency: the output pulse is (DATA_WIDTH+2+PAR_EN)*PRESCALE clocks after start detect.
//  - Back-to-back frames: a start bit immediately after stop is detected in IDLE
//    the following cycle.
//  - RX_IN held low for a full frame: STP_ERR pulses, then a new start is detected
//    from IDLE.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN
//    defined:   each bit = majority of RX_IN at edge_cnt S-1, S, S+1.
//    undefined: each bit = RX_IN at edge_cnt S only.
//  Latency and ports are identical in both builds.
// TESTING
//  1. PRESCALE=8, PAR_EN=0, frame 0xA5 with stop=1 -> DATA_VALID for 1 cycle at 80 clks
//     after start, P_DATA=0xA5, no errors.
//  2. PRESCALE=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity 0 -> P_DATA=0x3C.
//     Repeat with parity 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA stays 0x3C.
//  3. PRESCALE=8, data 0x55, stop=0 -> STP_ERR pulse, DATA_VALID=0.
//  4. PRESCALE=16, RX_IN low for 3 clks then high -> returns to IDLE, no pulses,
//     RX_BUSY low after 16 clks.
//  5. With macro, 1-clk glitch at S of bit 3 of 0x00 -> P_DATA=0x00.
//     Without macro, same stimulus -> P_DATA=0x08.
//  6. RST low during DATA of a 0xFF frame -> all outputs 0; next clean 0x81 frame
//     -> P_DATA=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Deframes start/data/[parity]/stop, LSB
// first, at PRESCALE clocks per bit and emits a one-cycle DATA_VALID pulse with
// the word, or PAR_ERR / STP_ERR pulses for bad frames.
// Build option: define UART_RX_MAJORITY_VOTE_EN to take each bit as the
// majority of three samples around mid-bit instead of a single mid-bit sample.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low (that cycle is edge 0 of start)
// START  | qualifying start bit; high at sample point means false start
// DATA   | shifting in DATA_WIDTH bits, LSB first
// PARITY | checking parity bit against received data
// STOP   | checking stop bit, then issuing result pulse

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  RX_BUSY
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [PRESCALE_W-1:0] ONE_P   = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  ONE_B   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_flag_q;
  logic                    bit_val;
  logic                    last_edge;
  logic                    start_det;
  logic [PRESCALE_W-1:0]   samp_pt;
  logic                    dv_d, pe_d, se_d;

  assign samp_pt   = presc_q >> 1;
  assign last_edge = (edge_cnt == (presc_q - ONE_P));
  assign start_det = (state_q == S_IDLE) && !RX_IN;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp_m1, samp_mid, samp_p1;

  // Capture the line one clock before, at, and one clock after the sample point
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_m1  <= 1'b1;
      samp_mid <= 1'b1;
      samp_p1  <= 1'b1;
    end else if (state_q != S_IDLE) begin
      if (edge_cnt == (samp_pt - ONE_P)) samp_m1  <= RX_IN;
      if (edge_cnt == samp_pt)           samp_mid <= RX_IN;
      if (edge_cnt == (samp_pt + ONE_P)) samp_p1  <= RX_IN;
    end
  end

  assign bit_val = (samp_m1 & samp_mid) | (samp_m1 & samp_p1) | (samp_mid & samp_p1);
`else
  logic samp_mid;

  // Capture the line at the mid-bit sample point
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_mid <= 1'b1;
    end else if (state_q != S_IDLE && edge_cnt == samp_pt) begin
      samp_mid <= RX_IN;
    end
  end

  assign bit_val = samp_mid;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; all bit decisions happen on the last edge of a bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!RX_IN) state_d = S_START;
      S_START:  if (last_edge) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (last_edge && bit_cnt == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (last_edge) state_d = S_STOP;
      S_STOP:   if (last_edge) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Result decode for the cycle the stop bit is decided
  always_comb begin
    dv_d = 1'b0;
    pe_d = 1'b0;
    se_d = 1'b0;
    if (state_q == S_STOP && last_edge) begin
      dv_d = bit_val && !par_flag_q;
      pe_d = par_flag_q;
      se_d = !bit_val;
    end
  end

  // Per-bit edge counter; the start-detect cycle counts as edge 0
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   edge_cnt <= '0;
    else if (state_q == S_IDLE) edge_cnt <= RX_IN ? '0 : ONE_P;
    else if (last_edge)         edge_cnt <= '0;
    else                        edge_cnt <= edge_cnt + ONE_P;
  end

  // Frame configuration frozen at start detect so mid-frame changes are ignored
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (start_det) begin
      presc_q   <= PRESCALE;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  // Data shift register, bit counter and parity mismatch flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
    end else begin
      case (state_q)
        S_START: begin
          bit_cnt    <= '0;
          par_flag_q <= 1'b0;
        end
        S_DATA: if (last_edge) begin
          shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + ONE_B;
        end
        S_PARITY: if (last_edge) begin
          par_flag_q <= bit_val ^ (^shift_q) ^ par_typ_q;
        end
        default: ;
      endcase
    end
  end

  // Registered result pulses; P_DATA only updates on a good frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= dv_d;
      PAR_ERR    <= pe_d;
      STP_ERR    <= se_d;
      if (dv_d) P_DATA <= shift_q;
    end
  end

  assign RX_BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives frames cycle by cycle and checks pulse
// timing, data and error flags against hand-computed values.

module tb_uart_rx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] PRESCALE = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_ERR;
  logic          STP_ERR;
  logic          RX_BUSY;

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .RX_BUSY    (RX_BUSY)
  );

  always #5 CLK = ~CLK;

  int   n_assert = 0;
  int   n_fail = 0;
  int   dv_cnt, dv_first, dv_last;
  int   pe_cnt, pe_at;
  int   se_cnt, se_at;
  logic busy_hist [0:255];

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [31:0] GLITCH_EXP = 32'h00;
`else
  localparam logic [31:0] GLITCH_EXP = 32'h08;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit vector, index 0 is the start bit
  function automatic logic [31:0] frame(input logic [7:0] d, input logic par_on,
                                        input logic par_bit, input logic stop_bit);
    logic [31:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par_on) begin
      f[9]  = par_bit;
      f[10] = stop_bit;
    end else begin
      f[9] = stop_bit;
    end
    return f;
  endfunction

  // Iteration c drives the level of cycle c and observes outputs after edge c,
  // so a pulse L clocks after start detect is seen at c == L.
  task automatic send(input logic [31:0] bits, input int nbits, input int bitlen,
                      input int cycles, input int glitch, input int chg);
    logic lvl;
    dv_cnt = 0; dv_first = -1; dv_last = -1;
    pe_cnt = 0; pe_at = -1;
    se_cnt = 0; se_at = -1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK);
      #1;
      if (DATA_VALID) begin
        if (dv_cnt == 0) dv_first = c;
        dv_last = c;
        dv_cnt++;
      end
      if (PAR_ERR) begin pe_cnt++; pe_at = c; end
      if (STP_ERR) begin se_cnt++; se_at = c; end
      if (c < 256) busy_hist[c] = RX_BUSY;
      lvl = (c < nbits * bitlen) ? bits[c / bitlen] : 1'b1;
      if (c == glitch) lvl = ~lvl;
      RX_IN = lvl;
      if (c == chg) begin
        PRESCALE = 6'd16;
        PAR_EN   = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pdata", 32'(P_DATA), 32'h0);
    check("rst_dv", 32'(DATA_VALID), 32'h0);
    check("rst_pe", 32'(PAR_ERR), 32'h0);
    check("rst_se", 32'(STP_ERR), 32'h0);
    check("rst_busy", 32'(RX_BUSY), 32'h0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // 0xA5, PRESCALE 8, no parity; config changed mid-frame must be ignored
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send(frame(8'hA5, 1'b0, 1'b0, 1'b1), 10, 8, 84, -1, 20);
    check("t1_dv_cnt", dv_cnt, 1);
    check("t1_dv_at", dv_first, 80);
    check("t1_pdata", 32'(P_DATA), 32'hA5);
    check("t1_pe_cnt", pe_cnt, 0);
    check("t1_se_cnt", se_cnt, 0);
    check("t1_busy79", 32'(busy_hist[79]), 32'h1);
    check("t1_busy80", 32'(busy_hist[80]), 32'h0);

    // 0x3C, PRESCALE 16, even parity, correct parity bit 0
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send(frame(8'h3C, 1'b1, 1'b0, 1'b1), 11, 16, 180, -1, -1);
    check("t2_dv_cnt", dv_cnt, 1);
    check("t2_dv_at", dv_first, 176);
    check("t2_pdata", 32'(P_DATA), 32'h3C);
    check("t2_pe_cnt", pe_cnt, 0);

    // Same with wrong parity bit 1
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send(frame(8'h3C, 1'b1, 1'b1, 1'b1), 11, 16, 180, -1, -1);
    check("t2b_pe_cnt", pe_cnt, 1);
    check("t2b_pe_at", pe_at, 176);
    check("t2b_dv_cnt", dv_cnt, 0);
    check("t2b_se_cnt", se_cnt, 0);
    check("t2b_pdata", 32'(P_DATA), 32'h3C);

    // Odd parity: 0x07 has three ones, so parity bit 0 is correct
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send(frame(8'h07, 1'b1, 1'b0, 1'b1), 11, 8, 92, -1, -1);
    check("t2c_dv_at", dv_first, 88);
    check("t2c_pe_cnt", pe_cnt, 0);
    check("t2c_pdata", 32'(P_DATA), 32'h07);

    // 0x55 with stop bit 0
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send(frame(8'h55, 1'b0, 1'b0, 1'b0), 10, 8, 84, -1, -1);
    check("t3_se_cnt", se_cnt, 1);
    check("t3_se_at", se_at, 80);
    check("t3_dv_cnt", dv_cnt, 0);
    check("t3_pdata", 32'(P_DATA), 32'h07);

    // Parity and stop error together: 0x01 even parity wants 1, send 0, stop 0
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send(frame(8'h01, 1'b1, 1'b0, 1'b0), 11, 8, 92, -1, -1);
    check("t3b_pe_at", pe_at, 88);
    check("t3b_se_at", se_at, 88);
    check("t3b_dv_cnt", dv_cnt, 0);

    // False start: low for 3 clocks at PRESCALE 16
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    send(32'hFFFF_FFF8, 32, 1, 24, -1, -1);
    check("t4_busy1", 32'(busy_hist[1]), 32'h1);
    check("t4_busy15", 32'(busy_hist[15]), 32'h1);
    check("t4_busy16", 32'(busy_hist[16]), 32'h0);
    check("t4_pulses", dv_cnt + pe_cnt + se_cnt, 0);

    // 0x00 with a one-clock glitch at the sample point of data bit 3
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    send(frame(8'h00, 1'b0, 1'b0, 1'b1), 10, 8, 84, 36, -1);
    check("t5_dv_at", dv_first, 80);
    check("t5_pdata", 32'(P_DATA), GLITCH_EXP);

    // Back-to-back frames 0x12 then 0x34 with no idle gap
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    send({12'hFFF, frame(8'h34, 1'b0, 1'b0, 1'b1)[9:0], frame(8'h12, 1'b0, 1'b0, 1'b1)[9:0]},
         20, 8, 164, -1, -1);
    check("t6_dv_cnt", dv_cnt, 2);
    check("t6_dv_first", dv_first, 80);
    check("t6_dv_last", dv_last, 160);
    check("t6_pdata", 32'(P_DATA), 32'h34);

    // Line low for a whole frame plus one more clock: stop error, then a new
    // start from IDLE that turns out to be false
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    send(32'h0, 10, 8, 100, 80, -1);
    check("t7_se_at", se_at, 80);
    check("t7_dv_cnt", dv_cnt, 0);
    check("t7_busy80", 32'(busy_hist[80]), 32'h0);
    check("t7_busy81", 32'(busy_hist[81]), 32'h1);
    check("t7_busy88", 32'(busy_hist[88]), 32'h0);

    // Reset in the middle of a 0xFF frame
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    send(frame(8'hFF, 1'b0, 1'b0, 1'b1), 10, 8, 40, -1, -1);
    check("t8_busy_pre", 32'(RX_BUSY), 32'h1);
    check("t8_dv_pre", dv_cnt, 0);
    RST = 1'b0;
    #1;
    check("t8_rst_pdata", 32'(P_DATA), 32'h0);
    check("t8_rst_busy", 32'(RX_BUSY), 32'h0);
    check("t8_rst_flags", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'h0);
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    send(frame(8'h81, 1'b0, 1'b0, 1'b1), 10, 8, 84, -1, -1);
    check("t8_dv_cnt", dv_cnt, 1);
    check("t8_dv_at", dv_first, 80);
    check("t8_pdata", 32'(P_DATA), 32'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
